banco_registradores_pilha: RTL

Parametrised data register file with an integrated return-address stack for call/return (jump-and-link) support. It generalises the processor's register bank in data width, register count and stack depth. It adds full/empty/error reporting, simultaneous push+pop, and an optional write-to-read bypass. It sits in the decode stage: it is read combinationally by the ALU path, written by the control unit, and feeds `jl` to the PC logic.

---
 rtl/banco_registradores_pilha_if.sv | 45 ++++
 rtl/banco_registradores_pilha.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/banco_registradores_pilha_if.sv
// Bundle of register-file and return-stack signals between the control unit (master) and the bank (slave).
interface banco_registradores_pilha_if #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 32
);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic              reg_write;
  logic              imm;
  logic              move;
  logic              push;
  logic              pop;
  logic              clear_err;
  logic [REG_AW-1:0] ler_reg1;
  logic [REG_AW-1:0] ler_reg2;
  logic [REG_AW-1:0] esc_reg;
  logic [DATA_W-1:0] dado;
  logic [DATA_W-1:0] estendido;
  logic [PC_W-1:0]   end_atual;
  logic [DATA_W-1:0] lido1;
  logic [DATA_W-1:0] lido2;
  logic [DATA_W-1:0] lido3;
  logic [PC_W-1:0]   jl;
  logic              jl_valid;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;
  logic [CNT_W-1:0]  stack_count;

  modport master (
    output reg_write, imm, move, push, pop, clear_err,
    output ler_reg1, ler_reg2, esc_reg, dado, estendido, end_atual,
    input  lido1, lido2, lido3, jl, jl_valid,
    input  stack_full, stack_empty, stack_err, stack_count
  );

  modport slave (
    input  reg_write, imm, move, push, pop, clear_err,
    input  ler_reg1, ler_reg2, esc_reg, dado, estendido, end_atual,
    output lido1, lido2, lido3, jl, jl_valid,
    output stack_full, stack_empty, stack_err, stack_count
  );
endinterface

// File: rtl/banco_registradores_pilha.sv
// Register bank with integrated return-address stack; state updates on the falling edge of sys_clock.
// Optional macro BANCO_BYPASS_EN forwards the pending write/move value to matching read ports.
module banco_registradores_pilha #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 32
) (
  input logic sys_clock,
  input logic reset,
  banco_registradores_pilha_if.slave bus
);
  localparam int NREG  = 1 << REG_AW;
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  // ---------------- register path ----------------
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mv_data;
  logic              mv_act;

  function automatic logic [DATA_W-1:0] rd_stored(input logic [REG_AW-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  assign wr_data = bus.imm ? bus.estendido : bus.dado;
  assign mv_data = rd_stored(bus.ler_reg1);
  // A move onto itself is a no-op; a simultaneous write always takes precedence.
  assign mv_act  = bus.move && !bus.reg_write && (bus.esc_reg != bus.ler_reg1);

  function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] a);
    logic [DATA_W-1:0] v;
    v = rd_stored(a);
`ifdef BANCO_BYPASS_EN
    if (a != '0) begin
      if (bus.reg_write && a == bus.esc_reg)
        v = wr_data;
      else if (mv_act && a == bus.esc_reg)
        v = mv_data;
      else if (mv_act && a == bus.ler_reg1)
        v = '0;
    end
`endif
    return v;
  endfunction

  assign bus.lido1 = rd_port(bus.ler_reg1);
  assign bus.lido2 = rd_port(bus.ler_reg2);
  assign bus.lido3 = rd_port(bus.esc_reg);

  always_ff @(negedge sys_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.reg_write) begin
      if (bus.esc_reg != '0) regs[bus.esc_reg] <= wr_data;
    end else if (mv_act) begin
      // NOTE: non-blocking assignments make both moves see the pre-edge array, so order is irrelevant.
      if (bus.esc_reg != '0)  regs[bus.esc_reg]  <= mv_data;
      if (bus.ler_reg1 != '0) regs[bus.ler_reg1] <= '0;
    end
  end

  // ---------------- return-address stack ----------------
  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SP_W-1:0]  top_idx;
  logic [SP_W-1:0]  wr_idx;
  logic [PC_W-1:0]  ret_addr;
  logic             do_write;
  logic             pop_ok;
  logic             err_now;
  logic             full;
  logic             empty;
  logic             jl_valid_q;
  logic             err_q;
  logic [PC_W-1:0]  jl_q;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign top_idx  = SP_W'(count - CNT_W'(1));
  assign ret_addr = bus.end_atual + PC_W'(1);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    do_write = 1'b0;
    pop_ok   = 1'b0;
    err_now  = 1'b0;
    wr_idx   = top_idx;
    cnt_nxt  = count;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (full) begin
          err_now = 1'b1;
        end else begin
          do_write = 1'b1;
          wr_idx   = SP_W'(count);
          cnt_nxt  = count + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          err_now = 1'b1;
        end else begin
          pop_ok  = 1'b1;
          cnt_nxt = count - CNT_W'(1);
        end
      end
      2'b11: begin
        do_write = 1'b1;
        if (empty) begin
          wr_idx  = '0;
          cnt_nxt = CNT_W'(1);
        end else begin
          pop_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge sys_clock or posedge reset) begin
    if (reset) begin
      count            <= '0;
      jl_q             <= '0;
      jl_valid_q       <= 1'b0;
      err_q            <= 1'b0;
      bus.stack_empty  <= 1'b1;
      bus.stack_full   <= 1'b0;
    end else begin
      count            <= cnt_nxt;
      jl_valid_q       <= pop_ok;
      if (pop_ok) jl_q <= stack_mem[top_idx];
      err_q            <= err_now | (err_q & ~bus.clear_err);
      bus.stack_empty  <= (cnt_nxt == '0);
      bus.stack_full   <= (cnt_nxt == DEPTH_C);
    end
  end

  // NOTE: the stack RAM has no reset; count alone defines which entries are valid.
  always_ff @(negedge sys_clock) begin
    if (do_write) stack_mem[wr_idx] <= ret_addr;
  end

  assign bus.jl          = jl_q;
  assign bus.jl_valid    = jl_valid_q;
  assign bus.stack_err   = err_q;
  assign bus.stack_count = count;
endmodule
